// File: rtl/dma_pkg.sv
// Shared types for the DMA transfer sequencer: FSM encoding, transfer type/mode codes.
package dma_pkg;

  localparam int NUM_CH_MAX = 8;

  // Bit position of each state inside the one-hot state vector
  typedef enum int {
    SI_IDX = 0,
    S0_IDX = 1,
    S1_IDX = 2,
    S2_IDX = 3,
    S3_IDX = 4,
    S4_IDX = 5
  } state_idx_e;

  typedef enum logic [5:0] {
    ST_SI = 6'b000001,
    ST_S0 = 6'b000010,
    ST_S1 = 6'b000100,
    ST_S2 = 6'b001000,
    ST_S3 = 6'b010000,
    ST_S4 = 6'b100000
  } state_e;

  // 11 is decoded as verify
  typedef enum logic [1:0] {
    XT_VERIFY  = 2'b00,
    XT_WRITE   = 2'b01,
    XT_READ    = 2'b10,
    XT_ILLEGAL = 2'b11
  } xfer_type_e;

  // 11 is decoded as single
  typedef enum logic [1:0] {
    XM_DEMAND  = 2'b00,
    XM_SINGLE  = 2'b01,
    XM_BLOCK   = 2'b10,
    XM_ILLEGAL = 2'b11
  } xfer_mode_e;

endpackage

// File: rtl/dma_chan_arbiter.sv
// Channel arbiter: fixed (ch0 highest) or rotating priority starting at i_ptr.
module dma_chan_arbiter
  import dma_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CH_W   = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] i_req,
  input  logic              i_rot_en,
  input  logic [CH_W-1:0]   i_ptr,
  output logic              o_any,
  output logic [NUM_CH-1:0] o_gnt,
  output logic [CH_W-1:0]   o_ptr_nxt
);

  logic [CH_W-1:0] w_idx;
  int              w_base;
  int              w_c;

  // Scan channels from the highest-priority slot; first requester wins
  always_comb begin
    o_gnt  = '0;
    w_idx  = '0;
    o_any  = 1'b0;
    w_c    = 0;
    w_base = i_rot_en ? int'(i_ptr) : 0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_c = w_base + i;
      if (w_c >= NUM_CH) w_c = w_c - NUM_CH;
      if (!o_any && i_req[w_c[CH_W-1:0]]) begin
        o_any                = 1'b1;
        o_gnt[w_c[CH_W-1:0]] = 1'b1;
        w_idx                = w_c[CH_W-1:0];
      end
    end
  end

  // Winner becomes lowest priority: next scan starts one past it
  assign o_ptr_nxt = (w_idx == CH_W'(NUM_CH - 1)) ? '0 : w_idx + 1'b1;

endmodule

// File: rtl/dma_xfer_sequencer_chk.sv
// Bus protocol checker, bound into every dma_xfer_sequencer instance.
module dma_xfer_sequencer_chk #(
  parameter int NUM_CH = 4
) (
  input logic              CLK,
  input logic              RESET_N,
  input logic              HRQ,
  input logic              AEN,
  input logic              ADSTB,
  input logic [NUM_CH-1:0] DACK
);

  a_adstb_single: assert property (@(posedge CLK) disable iff (!RESET_N) ADSTB |=> !ADSTB);
  a_aen_hrq:      assert property (@(posedge CLK) disable iff (!RESET_N) AEN |-> HRQ);
  a_dack_onehot:  assert property (@(posedge CLK) disable iff (!RESET_N) $onehot0(DACK));

endmodule

bind dma_xfer_sequencer dma_xfer_sequencer_chk #(.NUM_CH(NUM_CH)) u_chk (
  .CLK(CLK), .RESET_N(RESET_N), .HRQ(HRQ), .AEN(AEN), .ADSTB(ADSTB), .DACK(DACK)
);

// File: rtl/dma_xfer_sequencer.sv
// DMA transfer sequencer: arbitration, HRQ/HLDA handshake, SI..S4 cycle FSM, strobe decode.
module dma_xfer_sequencer
  import dma_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int CH_W        = $clog2(NUM_CH),
  parameter int ROTATE_PRIO = 0
) (
  input  logic                CLK,
  input  logic                RESET_N,
  input  logic                CS_N,
  input  logic [NUM_CH-1:0]   DREQ,
  input  logic [NUM_CH-1:0]   ch_enable,
  input  logic [2*NUM_CH-1:0] xfer_type,
  input  logic [2*NUM_CH-1:0] xfer_mode,
  input  logic [NUM_CH-1:0]   autoinit,
  input  logic                rot_prio,
  input  logic                tc,
  input  logic                HLDA,
  input  logic                READY,
  input  logic                EOP_N_in,
  output logic                HRQ,
  output logic                AEN,
  output logic                ADSTB,
  output logic [NUM_CH-1:0]   DACK,
  output logic                ior,
  output logic                iow,
  output logic                memr,
  output logic                memw,
  output logic                load_addr,
  output logic                decr_wc,
  output logic                incr_addr,
  output logic                update_cur,
  output logic                reload_base,
  output logic                int_eop,
  output logic [NUM_CH-1:0]   tc_status
);

  state_e            r_state;
  logic [NUM_CH-1:0] r_gnt;
  logic [CH_W-1:0]   r_ptr;
  logic              r_rot_en;
  logic              r_term;
  logic [NUM_CH-1:0] r_tc_status;

  logic [NUM_CH-1:0] w_req;
  logic              w_arb_any;
  logic [NUM_CH-1:0] w_arb_gnt;
  logic [CH_W-1:0]   w_arb_ptr_nxt;
  xfer_type_e        w_type;
  xfer_mode_e        w_mode;
  logic              w_dreq_g;
  logic              w_auto;
  logic              w_own;
  logic              w_xfer;
  logic              w_s4_ok;
  logic              w_term;

  // CPU programming (CS_N low) suppresses all new requests
  assign w_req = DREQ & ch_enable & {NUM_CH{CS_N}};

  dma_chan_arbiter #(.NUM_CH(NUM_CH), .CH_W(CH_W)) u_arb (
    .i_req     (w_req),
    .i_rot_en  (r_rot_en),
    .i_ptr     (r_ptr),
    .o_any     (w_arb_any),
    .o_gnt     (w_arb_gnt),
    .o_ptr_nxt (w_arb_ptr_nxt)
  );

  // Pick the granted channel's type and mode fields
  always_comb begin
    w_type = XT_VERIFY;
    w_mode = XM_SINGLE;
    for (int i = 0; i < NUM_CH; i++) begin
      if (r_gnt[i]) begin
        w_type = xfer_type_e'(xfer_type[2*i +: 2]);
        w_mode = xfer_mode_e'(xfer_mode[2*i +: 2]);
      end
    end
  end

  assign w_dreq_g = |(DREQ & r_gnt);
  assign w_auto   = |(autoinit & r_gnt);

  // Termination seen in S2/S3 is remembered; S4 also looks at the live inputs
  assign w_term = r_term | tc | ~EOP_N_in;

  // Sequencer FSM: grant latch, pointer, sticky TC flags, termination memory
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state     <= ST_SI;
      r_gnt       <= '0;
      r_ptr       <= '0;
      r_rot_en    <= (ROTATE_PRIO != 0);
      r_term      <= 1'b0;
      r_tc_status <= '0;
    end else begin
      r_rot_en <= rot_prio;
      case (r_state)
        ST_SI: begin
          r_term <= 1'b0;
          if (!CS_N) begin
            r_tc_status <= '0;
          end else if (w_arb_any) begin
            r_state <= ST_S0;
            r_gnt   <= w_arb_gnt;
            r_ptr   <= w_arb_ptr_nxt;
          end
        end
        // HRQ held even if DREQ drops; no re-arbitration here
        ST_S0: if (HLDA) r_state <= ST_S1;
        ST_S1: r_state <= HLDA ? ST_S2 : ST_SI;
        ST_S2, ST_S3: begin
          if (!HLDA) begin
            r_state <= ST_SI;
          end else begin
            if (tc || !EOP_N_in) r_term <= 1'b1;
            r_state <= READY ? ST_S4 : ST_S3;
          end
        end
        ST_S4: begin
          if (!HLDA) begin
            r_state <= ST_SI;
          end else if (w_term) begin
            r_tc_status <= r_tc_status | r_gnt;
            r_state     <= ST_SI;
          end else begin
            case (w_mode)
              XM_BLOCK:  r_state <= ST_S2;
              XM_DEMAND: r_state <= w_dreq_g ? ST_S2 : ST_SI;
              default:   r_state <= ST_SI;
            endcase
          end
        end
        default: r_state <= ST_SI;
      endcase
    end
  end

  // Bus outputs are straight decodes of the one-hot state flops
  assign w_own     = r_state[S1_IDX] | r_state[S2_IDX] | r_state[S3_IDX] | r_state[S4_IDX];
  assign w_xfer    = r_state[S2_IDX] | r_state[S3_IDX];
  assign HRQ       = r_state[S0_IDX] | w_own;
  assign AEN       = w_own;
  assign ADSTB     = r_state[S1_IDX];
  assign load_addr = r_state[S1_IDX];
  assign DACK      = w_own ? r_gnt : '0;
  assign ior       = w_xfer & (w_type == XT_WRITE);
  assign memw      = w_xfer & (w_type == XT_WRITE);
  assign iow       = w_xfer & (w_type == XT_READ);
  assign memr      = w_xfer & (w_type == XT_READ);

  // Update strobes are suppressed when HLDA has been withdrawn (abort)
  assign w_s4_ok     = r_state[S4_IDX] & HLDA;
  assign decr_wc     = w_s4_ok;
  assign incr_addr   = w_s4_ok;
  assign update_cur  = w_s4_ok;
  assign int_eop     = w_s4_ok & w_term;
  assign reload_base = int_eop & w_auto;
  // Flag shows in the termination cycle itself, then stays sticky
  assign tc_status   = r_tc_status | ({NUM_CH{int_eop}} & r_gnt);

endmodule

// File: tb/tb_dma_xfer_sequencer.sv
// Directed bench for dma_xfer_sequencer; CPU HLDA answers HRQ one cycle late.
module tb_dma_xfer_sequencer;

  localparam logic [12:0] O_S0   = 13'b1000_0000_000_00;
  localparam logic [12:0] O_S1   = 13'b1111_0000_000_00;
  localparam logic [12:0] O_WR   = 13'b1100_1001_000_00;
  localparam logic [12:0] O_RD   = 13'b1100_0110_000_00;
  localparam logic [12:0] O_S4   = 13'b1100_0000_111_00;
  localparam logic [12:0] O_S4E  = 13'b1100_0000_111_01;
  localparam logic [12:0] O_S4ER = 13'b1100_0000_111_11;
  localparam logic [12:0] O_IDLE = 13'b0;

  logic       CLK = 1'b0;
  logic       RESET_N, CS_N, rot_prio, tc, READY, EOP_N_in;
  logic [3:0] DREQ, ch_enable, autoinit;
  logic [7:0] xfer_type, xfer_mode;
  logic       hlda_en, hrq_q;
  wire        HLDA;
  logic       HRQ, AEN, ADSTB, ior, iow, memr, memw, load_addr, decr_wc, incr_addr;
  logic       update_cur, reload_base, int_eop;
  logic [3:0] DACK, tc_status;
  int         cmp_n = 0;
  int         err_n = 0;

  always #5 CLK = ~CLK;

  // CPU model: acknowledges hold one cycle after HRQ, withdraws one after it drops
  always @(posedge CLK) hrq_q <= HRQ;
  assign HLDA = hlda_en & hrq_q;

  wire [12:0] w_obs = {HRQ, AEN, ADSTB, load_addr, ior, iow, memr, memw,
                       decr_wc, incr_addr, update_cur, reload_base, int_eop};

  dma_xfer_sequencer #(.NUM_CH(4)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .CS_N(CS_N), .DREQ(DREQ), .ch_enable(ch_enable),
    .xfer_type(xfer_type), .xfer_mode(xfer_mode), .autoinit(autoinit), .rot_prio(rot_prio),
    .tc(tc), .HLDA(HLDA), .READY(READY), .EOP_N_in(EOP_N_in), .HRQ(HRQ), .AEN(AEN),
    .ADSTB(ADSTB), .DACK(DACK), .ior(ior), .iow(iow), .memr(memr), .memw(memw),
    .load_addr(load_addr), .decr_wc(decr_wc), .incr_addr(incr_addr),
    .update_cur(update_cur), .reload_base(reload_base), .int_eop(int_eop),
    .tc_status(tc_status)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    RESET_N = 1'b0;
    idle(3);
    cmp_n++; if (w_obs !== O_IDLE) begin err_n++; $display("FAIL reset outputs got %b exp %b", w_obs, O_IDLE); end
    cmp_n++; if (DACK !== 4'h0) begin err_n++; $display("FAIL reset DACK got %b exp 0000", DACK); end
    cmp_n++; if (tc_status !== 4'h0) begin err_n++; $display("FAIL reset tc_status got %b exp 0000", tc_status); end
    RESET_N = 1'b1;
    hlda_en = 1'b1;
    idle(2);
  endtask

  task automatic test_single_write();
    logic [12:0] eo [6] = '{O_S0, O_S0, O_S1, O_WR, O_S4, O_IDLE};
    logic [3:0]  ed [6] = '{4'h0, 4'h0, 4'h2, 4'h2, 4'h2, 4'h0};
    idle(3);
    xfer_type = 8'b00_00_01_00; xfer_mode = 8'b00_00_01_00; DREQ = 4'b0010;
    for (int k = 0; k < 6; k++) begin
      tick();
      cmp_n++; if (w_obs !== eo[k]) begin err_n++; $display("FAIL single_wr out cyc%0d got %b exp %b", k, w_obs, eo[k]); end
      cmp_n++; if (DACK !== ed[k]) begin err_n++; $display("FAIL single_wr DACK cyc%0d got %b exp %b", k, DACK, ed[k]); end
      if (k == 2) DREQ = 4'b0;
    end
  endtask

  task automatic test_block_read();
    logic [12:0] eo [10] = '{O_S0, O_S0, O_S1, O_RD, O_S4, O_RD, O_S4, O_RD, O_S4ER, O_IDLE};
    logic [3:0]  ed [10] = '{4'h0, 4'h0, 4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 4'h0};
    int nadstb = 0;
    idle(3);
    xfer_type = 8'b00_00_00_10; xfer_mode = 8'b00_00_00_10; autoinit = 4'b0001; DREQ = 4'b0001;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (ADSTB) nadstb++;
      cmp_n++; if (w_obs !== eo[k]) begin err_n++; $display("FAIL block_rd out cyc%0d got %b exp %b", k, w_obs, eo[k]); end
      cmp_n++; if (DACK !== ed[k]) begin err_n++; $display("FAIL block_rd DACK cyc%0d got %b exp %b", k, DACK, ed[k]); end
      if (k >= 8) begin
        cmp_n++; if (tc_status !== 4'b0001) begin err_n++; $display("FAIL block_rd tc_status cyc%0d got %b exp 0001", k, tc_status); end
      end
      if (k == 7) tc = 1'b1;
      if (k == 8) begin tc = 1'b0; DREQ = 4'b0; end
    end
    cmp_n++; if (nadstb !== 1) begin err_n++; $display("FAIL block_rd adstb_count got %0d exp 1", nadstb); end
    autoinit = 4'b0;
  endtask

  task automatic test_demand();
    logic [12:0] eo [14] = '{O_S0, O_S0, O_S1, O_WR, O_S4, O_WR, O_S4, O_IDLE,
                             O_S0, O_S0, O_S1, O_WR, O_S4, O_IDLE};
    logic [3:0]  ed [14] = '{4'h0, 4'h0, 4'h4, 4'h4, 4'h4, 4'h4, 4'h4, 4'h0,
                             4'h0, 4'h0, 4'h4, 4'h4, 4'h4, 4'h0};
    idle(3);
    xfer_type = 8'b00_01_00_00; xfer_mode = 8'b00_00_00_00; DREQ = 4'b0100;
    for (int k = 0; k < 14; k++) begin
      tick();
      cmp_n++; if (w_obs !== eo[k]) begin err_n++; $display("FAIL demand out cyc%0d got %b exp %b", k, w_obs, eo[k]); end
      cmp_n++; if (DACK !== ed[k]) begin err_n++; $display("FAIL demand DACK cyc%0d got %b exp %b", k, DACK, ed[k]); end
      if (k == 6)  DREQ = 4'b0;
      if (k == 7)  DREQ = 4'b0100;
      if (k == 10) DREQ = 4'b0;
    end
  endtask

  task automatic test_ready_wait();
    logic [12:0] eo [9] = '{O_S0, O_S0, O_S1, O_WR, O_WR, O_WR, O_WR, O_S4, O_IDLE};
    logic [3:0]  ed [9] = '{4'h0, 4'h0, 4'h2, 4'h2, 4'h2, 4'h2, 4'h2, 4'h2, 4'h0};
    idle(3);
    xfer_type = 8'b00_00_01_00; xfer_mode = 8'b00_00_01_00; DREQ = 4'b0010;
    for (int k = 0; k < 9; k++) begin
      tick();
      cmp_n++; if (w_obs !== eo[k]) begin err_n++; $display("FAIL ready_wait out cyc%0d got %b exp %b", k, w_obs, eo[k]); end
      cmp_n++; if (DACK !== ed[k]) begin err_n++; $display("FAIL ready_wait DACK cyc%0d got %b exp %b", k, DACK, ed[k]); end
      if (k == 2) DREQ = 4'b0;
      if (k == 3) READY = 1'b0;
      if (k == 6) READY = 1'b1;
    end
  endtask

  // Grants alternate exp0/exp1 (equal values for fixed priority)
  task automatic test_priority(input logic rot, input int n, input logic [3:0] exp0, input logic [3:0] exp1);
    logic [3:0] got [4];
    int got_n = 0;
    int cyc = 0;
    RESET_N = 1'b0;
    idle(2);
    rot_prio = rot; xfer_type = 8'b0; xfer_mode = 8'b01_01_01_01; DREQ = 4'b1001;
    RESET_N = 1'b1;
    while (got_n < n && cyc < 200) begin
      tick();
      cyc++;
      if (ADSTB) begin got[got_n] = DACK; got_n++; end
    end
    DREQ = 4'b0;
    if (got_n < n) begin
      cmp_n++; err_n++;
      $display("FAIL prio rot=%0b timeout grants got %0d exp %0d", rot, got_n, n);
    end
    for (int i = 0; i < got_n; i++) begin
      cmp_n++;
      if (got[i] !== ((i % 2 == 0) ? exp0 : exp1)) begin
        err_n++;
        $display("FAIL prio rot=%0b grant%0d got %b exp %b", rot, i, got[i], (i % 2 == 0) ? exp0 : exp1);
      end
    end
    idle(6);
    rot_prio = 1'b0;
  endtask

  task automatic test_eop_abort();
    logic [12:0] eo [15] = '{O_S0, O_S0, O_S1, O_WR, O_WR, O_S4E, O_IDLE, O_IDLE, O_IDLE,
                             O_S0, O_S0, O_S1, O_RD, O_IDLE, O_IDLE};
    logic [3:0]  ed [15] = '{4'h0, 4'h0, 4'h8, 4'h8, 4'h8, 4'h8, 4'h0, 4'h0, 4'h0,
                             4'h0, 4'h0, 4'h1, 4'h1, 4'h0, 4'h0};
    idle(3);
    xfer_type = 8'b01_00_00_10; xfer_mode = 8'b10_00_00_01; DREQ = 4'b1000;
    for (int k = 0; k < 15; k++) begin
      tick();
      cmp_n++; if (w_obs !== eo[k]) begin err_n++; $display("FAIL eop_abort out cyc%0d got %b exp %b", k, w_obs, eo[k]); end
      cmp_n++; if (DACK !== ed[k]) begin err_n++; $display("FAIL eop_abort DACK cyc%0d got %b exp %b", k, DACK, ed[k]); end
      if (k == 5 || k == 6) begin
        cmp_n++; if (tc_status !== 4'b1000) begin err_n++; $display("FAIL eop tc_status cyc%0d got %b exp 1000", k, tc_status); end
      end
      if (k == 7) begin
        cmp_n++; if (tc_status !== 4'b0000) begin err_n++; $display("FAIL cs_clear tc_status got %b exp 0000", tc_status); end
      end
      case (k)
        2:  DREQ = 4'b0;
        3:  READY = 1'b0;
        4:  begin EOP_N_in = 1'b0; READY = 1'b1; end
        5:  EOP_N_in = 1'b1;
        6:  CS_N = 1'b0;
        7:  DREQ = 4'b0001;
        8:  CS_N = 1'b1;
        11: DREQ = 4'b0;
        12: hlda_en = 1'b0;
        default: ;
      endcase
    end
    hlda_en = 1'b1;
  endtask

  task automatic test_reset_mid();
    logic [12:0] eo [4] = '{O_S0, O_S0, O_S1, O_WR};
    idle(3);
    xfer_type = 8'b00_00_01_00; xfer_mode = 8'b00_00_01_00; DREQ = 4'b0010;
    for (int k = 0; k < 4; k++) begin
      tick();
      cmp_n++; if (w_obs !== eo[k]) begin err_n++; $display("FAIL reset_mid pre cyc%0d got %b exp %b", k, w_obs, eo[k]); end
      if (k == 2) DREQ = 4'b0;
    end
    #2 RESET_N = 1'b0;
    #1;
    cmp_n++; if (w_obs !== O_IDLE) begin err_n++; $display("FAIL reset_mid outputs got %b exp %b", w_obs, O_IDLE); end
    cmp_n++; if (DACK !== 4'h0) begin err_n++; $display("FAIL reset_mid DACK got %b exp 0000", DACK); end
    cmp_n++; if (tc_status !== 4'h0) begin err_n++; $display("FAIL reset_mid tc_status got %b exp 0000", tc_status); end
    idle(2);
    RESET_N = 1'b1;
    idle(2);
    cmp_n++; if (w_obs !== O_IDLE) begin err_n++; $display("FAIL reset_mid after got %b exp %b", w_obs, O_IDLE); end
  endtask

  initial begin
    RESET_N = 1'b0; CS_N = 1'b1; DREQ = 4'b0; ch_enable = 4'hF; xfer_type = 8'b0;
    xfer_mode = 8'b0; autoinit = 4'b0; rot_prio = 1'b0; tc = 1'b0; READY = 1'b1;
    EOP_N_in = 1'b1; hlda_en = 1'b0;
    test_reset();
    test_single_write();
    test_block_read();
    test_demand();
    test_ready_wait();
    test_priority(1'b1, 4, 4'b0001, 4'b1000);
    test_priority(1'b0, 3, 4'b0001, 4'b0001);
    test_eop_abort();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

endmodule
